irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Wishbone-mapped interrupt controller: the controller end of the core's meip/fast_irq/irq_ack interrupt interface.
- Collects NUM_SRC external sources and funnels them into the single machine-external interrupt line with claim/complete semantics.
- Drives the 16 fast-interrupt lines from software-visible pending/enable registers.
- Sits beside barebones_wb_top on the data-bus Wishbone. Its meip_o/fast_irq_o feed the core's meip_i/fast_irq_i, and the core's irq_ack_o feeds irq_ack_i.

Parameters:
- NUM_SRC, 8, number of external sources on meip path (1..31); ids 1..NUM_SRC, id 0 = none
- NUM_FAST, 16, number of fast interrupt lines (fixed to core width)

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous active-high reset
- src_i  in  NUM_SRC  external interrupt sources, synchronous to clk_i unless IRQ_SYNC_EN
- fast_src_i  in  NUM_FAST  fast interrupt sources, rising-edge triggered
- irq_ack_i  in  1  one-cycle pulse from core when it takes the external trap
- meip_o  out  1  machine external interrupt pending to core
- fast_irq_o  out  NUM_FAST  fast interrupt lines to core
- wb_cyc_i, wb_stb_i, wb_we_i  in  1  Wishbone classic slave controls
- wb_adr_i  in  32  byte address; only bits [4:2] decoded
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte selects; partial writes honoured per byte
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  transfer acknowledge

Behaviour:
- Reset: asynchronous, active-high. Every register and output goes to 0, FSM goes to IDLE. This applies mid-claim too; pending, in-service and claim id are all lost.
- Registers (word index):
  - 0 EXT_PEND (RO, bit k = id k+1)
  - 1 EXT_EN (RW)
  - 2 EXT_TRIG (RW; 1 = edge, 0 = level)
  - 3 CLAIM (RO; captured id while CLAIMED, else 0)
  - 4 COMPLETE (WO; write id)
  - 5 FAST_PEND (R/W1C)
  - 6 FAST_EN (RW)
  - 7 reads 0
  - Unused high bits read 0.
- Wishbone: ack asserted the cycle after cyc&stb&!ack. Ack is a one-cycle pulse, so a held stb yields one ack per two cycles. Write takes effect at the ack edge. wb_dat_o is valid with ack and 0 otherwise.
- Gateway, per external source:
  - Edge mode: pending set on 0→1 of src (previous sample register).
  - Level mode: pending tracks src while that source is not in service.
  - Pending sets one cycle after the source sample.
- Arbitration: lowest set index of (EXT_PEND & EXT_EN) wins.
- FSM:
  - IDLE: any enabled pending → ASSERT; meip_o registered high on that transition. Latency: src rises at cycle N, pending at N+1, meip_o at N+2.
  - ASSERT: if enabled pending vanishes (EXT_EN write), drop meip_o and return to IDLE. On irq_ack_i: capture winner id into claim register, clear its pending bit, meip_o←0, go to CLAIMED.
  - CLAIMED: meip_o held 0; the claimed source is masked from re-pending. A COMPLETE write with id == claim id goes to IDLE and clears the claim register. Mismatched ids are ignored.
- Stray inputs:
  - irq_ack_i in IDLE or CLAIMED: ignored.
  - irq_ack_i coinciding with the loss of an enabled pending in ASSERT: go to IDLE, no claim.
- Fast path:
  - FAST_PEND bit sets on rising edge of fast_src_i.
  - fast_irq_o = registered (FAST_PEND & FAST_EN), one cycle after pending.
  - Software write-1-to-clear; an edge in the same cycle as W1C wins (bit stays set).
  - irq_ack_i has no effect on the fast path.

Optional Feature:
- Macro IRQ_SYNC_EN.
- Defined: src_i and fast_src_i each pass through a 2-flop synchronizer before the gateway, adding 2 cycles (src rise at N → meip_o at N+4).
- Undefined: sources are sampled directly, with latency as above.

Decomposition:
- irq_ctrl_pkg: register word indices (REG_EXT_PEND..REG_FAST_EN), FSM state encoding (IDLE/ASSERT/CLAIMED), id width constant.
- Sub-module irq_gateway: one source's sync (optional), edge/level detection, pending bit, in-service masking. Instantiated NUM_SRC times via generate.

Test Plan:
- Reset with src_i=8'h04, EXT_EN=0 → meip_o=0, all reads 0. Assert reset_i mid-CLAIMED → CLAIM reads 0, meip_o=0.
- EXT_EN=8'hFF, EXT_TRIG=8'hFF, pulse src_i[2] at cycle N:
  - meip_o=1 at N+2.
  - irq_ack_i pulse → meip_o=0 next cycle, CLAIM=3, EXT_PEND=0.
  - COMPLETE=3 → IDLE.
- src_i[5] and src_i[1] rise same cycle:
  - First claim id=2; complete 2 → meip_o reasserts, claim id=6.
  - COMPLETE=4 during claim 6 ignored; state stays CLAIMED.
- Level source 0 held high through claim/complete:
  - No re-pend while claimed.
  - meip_o reasserts 2 cycles after COMPLETE=1.
- FAST_EN=16'h8001, edge on fast_src_i[15] → fast_irq_o=16'h8000. W1C 16'h8000 in the same cycle as a new edge → bit remains 1.
- IRQ_SYNC_EN build: src rise at N → meip_o at N+4. Back-to-back held wb_stb_i → ack every second cycle.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM states,
// claim id width and the Wishbone byte-select helper.
package irq_ctrl_pkg;

    localparam int ID_W = 5;

    localparam logic [2:0] REG_EXT_PEND  = 3'd0;
    localparam logic [2:0] REG_EXT_EN    = 3'd1;
    localparam logic [2:0] REG_EXT_TRIG  = 3'd2;
    localparam logic [2:0] REG_CLAIM     = 3'd3;
    localparam logic [2:0] REG_COMPLETE  = 3'd4;
    localparam logic [2:0] REG_FAST_PEND = 3'd5;
    localparam logic [2:0] REG_FAST_EN   = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ASSERT  = 2'd1,
        ST_CLAIMED = 2'd2
    } irq_state_e;

    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Wishbone classic bus bundle between the data-bus master and the interrupt
// controller register file.
interface irq_ctrl_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/irq_ctrl_gateway.sv
// Per-source gateway: optional 2-flop synchronizer (IRQ_SYNC_EN), edge/level
// detection, pending bit and in-service masking.
module irq_gateway (
    input  logic clk_i,
    input  logic reset_i,
    input  logic src_i,
    input  logic edge_i,
    input  logic claim_i,
    input  logic in_service_i,
    output logic pend_o
);

    logic smp;
    logic prev_q;
    logic pend_q, pend_d;

`ifdef IRQ_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) sync_q <= '0;
        else         sync_q <= {sync_q[0], src_i};
    end

    assign smp = sync_q[1];
`else
    assign smp = src_i;
`endif

    // Claim clears unconditionally; an in-service source cannot re-pend.
    always_comb begin
        pend_d = pend_q;
        if (claim_i) begin
            pend_d = 1'b0;
        end else if (!in_service_i) begin
            if (edge_i) pend_d = pend_q | (smp & ~prev_q);
            else        pend_d = smp;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            prev_q <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prev_q <= smp;
            pend_q <= pend_d;
        end
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// Wishbone-mapped interrupt controller: claim/complete arbitration onto meip_o
// plus edge-triggered fast interrupt lines. IRQ_SYNC_EN adds input synchronizers.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC  = 8,
    parameter int NUM_FAST = 16
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [NUM_SRC-1:0]  src_i,
    input  logic [NUM_FAST-1:0] fast_src_i,
    input  logic                irq_ack_i,
    output logic                meip_o,
    output logic [NUM_FAST-1:0] fast_irq_o,
    irq_ctrl_if.slave           wb
);

    logic                ack_q;
    logic [31:0]         dat_q;
    logic [NUM_SRC-1:0]  ext_en_q, ext_en_d;
    logic [NUM_SRC-1:0]  ext_trig_q, ext_trig_d;
    logic [NUM_SRC-1:0]  ext_pend;
    logic [NUM_FAST-1:0] fast_pend_q, fast_pend_d;
    logic [NUM_FAST-1:0] fast_en_q, fast_en_d;
    logic [NUM_FAST-1:0] fast_prev_q;
    logic [NUM_FAST-1:0] fast_irq_q;
    logic [NUM_FAST-1:0] fast_smp;
    logic [NUM_FAST-1:0] fast_w1c;

    irq_state_e          state_q;
    logic                meip_q;
    logic [ID_W-1:0]     claim_q;

    logic                wb_req, wb_wr;
    logic [2:0]          reg_idx;
    logic [31:0]         wr_mask, wr_data, rdata;
    logic                complete_wr;
    logic [ID_W-1:0]     complete_id;
    logic [NUM_SRC-1:0]  act;
    logic                any_act;
    logic [ID_W-1:0]     win_id;
    logic                claim_fire;
    logic                unused_bits;

    assign wb_req      = wb.wb_cyc_i && wb.wb_stb_i && !ack_q;
    assign wb_wr       = wb_req && wb.wb_we_i;
    assign reg_idx     = wb.wb_adr_i[4:2];
    assign wr_mask     = sel_mask(wb.wb_sel_i);
    assign wr_data     = wb.wb_dat_i & wr_mask;
    assign complete_wr = wb_wr && (reg_idx == REG_COMPLETE) && wb.wb_sel_i[0];
    assign complete_id = wb.wb_dat_i[ID_W-1:0];
    assign unused_bits = ^{wb.wb_adr_i, wr_mask, wr_data};

`ifdef IRQ_SYNC_EN
    logic [NUM_FAST-1:0] fast_s1_q, fast_s2_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fast_s1_q <= '0;
            fast_s2_q <= '0;
        end else begin
            fast_s1_q <= fast_src_i;
            fast_s2_q <= fast_s1_q;
        end
    end

    assign fast_smp = fast_s2_q;
`else
    assign fast_smp = fast_src_i;
`endif

    // Lowest enabled pending index wins.
    assign act     = ext_pend & ext_en_q;
    assign any_act = |act;

    always_comb begin
        win_id = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (act[k]) win_id = ID_W'(k + 1);
        end
    end

    assign claim_fire = (state_q == ST_ASSERT) && any_act && irq_ack_i;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_gw
        irq_gateway u_gw (
            .clk_i        (clk_i),
            .reset_i      (reset_i),
            .src_i        (src_i[k]),
            .edge_i       (ext_trig_q[k]),
            .claim_i      (claim_fire && (win_id == ID_W'(k + 1))),
            .in_service_i ((state_q == ST_CLAIMED) && (claim_q == ID_W'(k + 1))),
            .pend_o       (ext_pend[k])
        );
    end

    always_comb begin
        ext_en_d   = ext_en_q;
        ext_trig_d = ext_trig_q;
        fast_en_d  = fast_en_q;
        fast_w1c   = '0;
        if (wb_wr) begin
            case (reg_idx)
                REG_EXT_EN:    ext_en_d   = (ext_en_q & ~wr_mask[NUM_SRC-1:0]) | wr_data[NUM_SRC-1:0];
                REG_EXT_TRIG:  ext_trig_d = (ext_trig_q & ~wr_mask[NUM_SRC-1:0]) | wr_data[NUM_SRC-1:0];
                REG_FAST_EN:   fast_en_d  = (fast_en_q & ~wr_mask[NUM_FAST-1:0]) | wr_data[NUM_FAST-1:0];
                REG_FAST_PEND: fast_w1c   = wr_data[NUM_FAST-1:0];
                default: ;
            endcase
        end
        // A new edge in the same cycle as a W1C keeps the bit set.
        fast_pend_d = (fast_pend_q & ~fast_w1c) | (fast_smp & ~fast_prev_q);
    end

    always_comb begin
        rdata = '0;
        case (reg_idx)
            REG_EXT_PEND:  rdata[NUM_SRC-1:0]  = ext_pend;
            REG_EXT_EN:    rdata[NUM_SRC-1:0]  = ext_en_q;
            REG_EXT_TRIG:  rdata[NUM_SRC-1:0]  = ext_trig_q;
            REG_CLAIM:     rdata[ID_W-1:0]     = claim_q;
            REG_FAST_PEND: rdata[NUM_FAST-1:0] = fast_pend_q;
            REG_FAST_EN:   rdata[NUM_FAST-1:0] = fast_en_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            ext_en_q    <= '0;
            ext_trig_q  <= '0;
            fast_en_q   <= '0;
            fast_pend_q <= '0;
            fast_prev_q <= '0;
            fast_irq_q  <= '0;
        end else begin
            ack_q       <= wb_req;
            dat_q       <= wb_req ? rdata : 32'd0;
            ext_en_q    <= ext_en_d;
            ext_trig_q  <= ext_trig_d;
            fast_en_q   <= fast_en_d;
            fast_pend_q <= fast_pend_d;
            fast_prev_q <= fast_smp;
            fast_irq_q  <= fast_pend_q & fast_en_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            meip_q  <= 1'b0;
            claim_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_act) begin
                        state_q <= ST_ASSERT;
                        meip_q  <= 1'b1;
                    end
                end
                ST_ASSERT: begin
                    // Losing the enabled pending takes priority over a coincident ack.
                    if (!any_act) begin
                        state_q <= ST_IDLE;
                        meip_q  <= 1'b0;
                    end else if (irq_ack_i) begin
                        state_q <= ST_CLAIMED;
                        meip_q  <= 1'b0;
                        claim_q <= win_id;
                    end
                end
                ST_CLAIMED: begin
                    if (complete_wr && (complete_id == claim_q)) begin
                        state_q <= ST_IDLE;
                        claim_q <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    meip_q  <= 1'b0;
                    claim_q <= '0;
                end
            endcase
        end
    end

    assign meip_o      = meip_q;
    assign fast_irq_o  = fast_irq_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = dat_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed claim/complete scenarios plus
// randomized claim ordering and fast-path sequences against a behavioural model.
module tb_irq_ctrl;

    localparam int NUM_SRC  = 8;
    localparam int NUM_FAST = 16;
`ifdef IRQ_SYNC_EN
    localparam int SYNC_D = 2;
`else
    localparam int SYNC_D = 0;
`endif
    localparam int MEIP_LAT = 2 + SYNC_D;

    logic                clk = 1'b0;
    logic                reset_i = 1'b1;
    logic [NUM_SRC-1:0]  src_i = '0;
    logic [NUM_FAST-1:0] fast_src_i = '0;
    logic                irq_ack_i = 1'b0;
    logic                meip_o;
    logic [NUM_FAST-1:0] fast_irq_o;

    int checks = 0;
    int passed = 0;

    irq_ctrl_if wb ();

    irq_ctrl #(.NUM_SRC(NUM_SRC), .NUM_FAST(NUM_FAST)) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .src_i      (src_i),
        .fast_src_i (fast_src_i),
        .irq_ack_i  (irq_ack_i),
        .meip_o     (meip_o),
        .fast_irq_o (fast_irq_o),
        .wb         (wb)
    );

    always #5 clk = ~clk;

    task automatic wb_xfer(input logic we, input logic [2:0] idx, input logic [31:0] d,
                           input logic [3:0] sel, output logic [31:0] q);
        bit got = 0;
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = we;
        wb.wb_adr_i = {27'd0, idx, 2'b00}; wb.wb_dat_i = d; wb.wb_sel_i = sel;
        q = '0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk); #1;
            if (wb.wb_ack_o) begin got = 1; q = wb.wb_dat_o; end
        end
        if (!got) begin
            checks++;
            $display("FAIL wb_ack_timeout idx=%0d ack=0 required=1", idx);
        end
        @(negedge clk);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
    endtask

    task automatic wb_write(input logic [2:0] idx, input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, idx, d, sel, dummy);
    endtask

    task automatic wb_read(input logic [2:0] idx, output logic [31:0] q);
        wb_xfer(1'b0, idx, 32'd0, 4'hF, q);
    endtask

    task automatic wait_meip(output bit ok);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (meip_o) begin ok = 1; break; end
        end
    endtask

    task automatic pulse_ack();
        @(negedge clk); irq_ack_i = 1'b1;
        @(negedge clk); irq_ack_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] q;
        reset_i = 1'b1; src_i = 8'h04;
        repeat (3) @(negedge clk);
        checks++;
        if (meip_o !== 1'b0 || fast_irq_o !== '0 || wb.wb_ack_o !== 1'b0 || wb.wb_dat_o !== '0)
            $display("FAIL reset_outputs meip=%b fast=%h ack=%b dat=%h required all 0",
                     meip_o, fast_irq_o, wb.wb_ack_o, wb.wb_dat_o);
        else passed++;
        src_i = '0; reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb_read(3'(i), q);
            checks++;
            if (q !== 32'd0) $display("FAIL reset_read idx=%0d got=%h required=0", i, q);
            else passed++;
        end
    endtask

    task automatic test_edge_claim();
        logic [31:0] q;
        wb_write(3'd1, 32'hFF, 4'hF);
        wb_write(3'd2, 32'hFF, 4'hF);
        @(negedge clk); src_i[2] = 1'b1;
        for (int k = 1; k <= MEIP_LAT + 1; k++) begin
            @(negedge clk);
            checks++;
            if (meip_o !== (k >= MEIP_LAT))
                $display("FAIL edge_latency cycle=N+%0d meip=%b required=%b", k, meip_o, k >= MEIP_LAT);
            else passed++;
            if (k == 1) src_i[2] = 1'b0;
        end
        pulse_ack();
        checks++;
        if (meip_o !== 1'b0) $display("FAIL ack_drop meip=%b required=0", meip_o); else passed++;
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd3) $display("FAIL claim_id got=%0d required=3", q); else passed++;
        wb_read(3'd0, q);
        checks++;
        if (q !== 32'd0) $display("FAIL pend_after_claim got=%h required=0", q); else passed++;
        wb_write(3'd4, 32'd3, 4'hF);
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd0 || meip_o !== 1'b0)
            $display("FAIL complete_idle claim=%0d meip=%b required 0/0", q, meip_o);
        else passed++;
    endtask

    task automatic test_two_sources();
        logic [31:0] q;
        bit ok;
        @(negedge clk); src_i = 8'h22;
        @(negedge clk); src_i = 8'h00;
        wait_meip(ok);
        checks++;
        if (!ok) $display("FAIL two_meip meip=0 required=1"); else passed++;
        pulse_ack();
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd2) $display("FAIL two_first_claim got=%0d required=2", q); else passed++;
        wb_read(3'd0, q);
        checks++;
        if (q !== 32'h20) $display("FAIL two_pend got=%h required=20", q); else passed++;
        wb_write(3'd4, 32'd2, 4'hF);
        wait_meip(ok);
        checks++;
        if (!ok) $display("FAIL two_reassert meip=0 required=1"); else passed++;
        pulse_ack();
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd6) $display("FAIL two_second_claim got=%0d required=6", q); else passed++;
        wb_write(3'd4, 32'd4, 4'hF);
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd6 || meip_o !== 1'b0)
            $display("FAIL wrong_complete claim=%0d meip=%b required 6/0", q, meip_o);
        else passed++;
        wb_write(3'd4, 32'd6, 4'hF);
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd0) $display("FAIL two_final_claim got=%0d required=0", q); else passed++;
    endtask

    task automatic test_level();
        logic [31:0] q;
        bit ok;
        wb_write(3'd2, 32'hFE, 4'hF);
        @(negedge clk); src_i[0] = 1'b1;
        wait_meip(ok);
        checks++;
        if (!ok) $display("FAIL level_meip meip=0 required=1"); else passed++;
        pulse_ack();
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd1) $display("FAIL level_claim got=%0d required=1", q); else passed++;
        repeat (4) @(negedge clk);
        wb_read(3'd0, q);
        checks++;
        if (q !== 32'd0 || meip_o !== 1'b0)
            $display("FAIL level_no_repend pend=%h meip=%b required 0/0", q, meip_o);
        else passed++;
        wb_write(3'd4, 32'd1, 4'hF);
        for (int k = 0; k <= 2; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (meip_o !== (k == 2))
                $display("FAIL level_reassert cycle=%0d meip=%b required=%b", k, meip_o, k == 2);
            else passed++;
        end
        src_i[0] = 1'b0;
        repeat (SYNC_D + 3) @(negedge clk);
        checks++;
        if (meip_o !== 1'b0) $display("FAIL level_withdraw meip=%b required=0", meip_o); else passed++;
        wb_write(3'd2, 32'hFF, 4'hF);
    endtask

    task automatic test_reset_mid_claim();
        logic [31:0] q;
        bit ok;
        @(negedge clk); src_i[3] = 1'b1;
        @(negedge clk); src_i[3] = 1'b0;
        wait_meip(ok);
        pulse_ack();
        wb_read(3'd3, q);
        checks++;
        if (!ok || q !== 32'd4) $display("FAIL pre_reset_claim got=%0d required=4", q); else passed++;
        @(negedge clk); #2 reset_i = 1'b1; #1;
        checks++;
        if (meip_o !== 1'b0) $display("FAIL async_reset meip=%b required=0", meip_o); else passed++;
        @(negedge clk); reset_i = 1'b0;
        wb_read(3'd3, q);
        checks++;
        if (q !== 32'd0) $display("FAIL reset_claim got=%0d required=0", q); else passed++;
        wb_read(3'd1, q);
        checks++;
        if (q !== 32'd0) $display("FAIL reset_en got=%h required=0", q); else passed++;
    endtask

    task automatic test_fast();
        logic [31:0] q;
        wb_write(3'd6, 32'h0000_8001, 4'h3);
        @(negedge clk); fast_src_i[15] = 1'b1;
        repeat (1 + SYNC_D) @(negedge clk);
        checks++;
        if (fast_irq_o !== 16'h0000) $display("FAIL fast_early got=%h required=0000", fast_irq_o); else passed++;
        @(negedge clk);
        checks++;
        if (fast_irq_o !== 16'h8000) $display("FAIL fast_edge got=%h required=8000", fast_irq_o); else passed++;
        fast_src_i[15] = 1'b0;
        repeat (SYNC_D + 3) @(negedge clk);
        fast_src_i[15] = 1'b1;
        for (int i = 0; i < SYNC_D; i++) @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b1;
        wb.wb_adr_i = 32'h14; wb.wb_dat_i = 32'h8000; wb.wb_sel_i = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (wb.wb_ack_o !== 1'b1) $display("FAIL w1c_ack ack=%b required=1", wb.wb_ack_o); else passed++;
        @(negedge clk);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb_read(3'd5, q);
        checks++;
        if (q !== 32'h8000 || fast_irq_o !== 16'h8000)
            $display("FAIL w1c_edge_wins pend=%h irq=%h required 8000/8000", q, fast_irq_o);
        else passed++;
        wb_write(3'd5, 32'h8000, 4'hF);
        wb_read(3'd5, q);
        checks++;
        if (q !== 32'd0 || fast_irq_o !== 16'h0000)
            $display("FAIL w1c_clear pend=%h irq=%h required 0/0", q, fast_irq_o);
        else passed++;
        @(negedge clk); fast_src_i[0] = 1'b1;
        repeat (2 + SYNC_D) @(negedge clk);
        pulse_ack();
        checks++;
        if (fast_irq_o !== 16'h0001) $display("FAIL fast_ack_ignored got=%h required=0001", fast_irq_o); else passed++;
        fast_src_i = '0;
    endtask

    task automatic test_fast_random();
        logic [15:0] en, m_pend, m_irq, x, eff, eff_prev;
        logic [15:0] hist[$];
        en = 16'($urandom);
        wb_write(3'd6, {16'd0, en}, 4'hF);
        fast_src_i = '0;
        repeat (SYNC_D + 3) @(negedge clk);
        wb_write(3'd5, 32'hFFFF, 4'hF);
        @(negedge clk);
        m_pend = '0; m_irq = '0;
        hist = {16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (fast_irq_o !== m_irq)
                $display("FAIL fast_random step=%0d got=%h required=%h", i, fast_irq_o, m_irq);
            else passed++;
            x = 16'($urandom);
            fast_src_i = x;
            hist.push_back(x);
            eff      = hist[hist.size() - 1 - SYNC_D];
            eff_prev = hist[hist.size() - 2 - SYNC_D];
            m_irq  = m_pend & en;
            m_pend = m_pend | (eff & ~eff_prev);
            @(negedge clk);
        end
        fast_src_i = '0;
    endtask

    task automatic test_random_claims();
        logic [31:0] q;
        logic [7:0]  mask, en, remaining;
        int          exp_id;
        bit          ok;
        wb_write(3'd2, 32'hFF, 4'hF);
        for (int it = 0; it < 5; it++) begin
            mask = 8'($urandom_range(1, 255));
            en   = 8'($urandom);
            wb_write(3'd1, {24'd0, en}, 4'hF);
            @(negedge clk); src_i = mask;
            @(negedge clk); src_i = '0;
            for (int phase = 0; phase < 2; phase++) begin
                remaining = (phase == 0) ? (mask & en) : (mask & ~en);
                if (phase == 1) wb_write(3'd1, 32'hFF, 4'hF);
                for (int n = 0; n < 8 && remaining != 0; n++) begin
                    exp_id = 0;
                    for (int b = 7; b >= 0; b--) if (remaining[b]) exp_id = b + 1;
                    wait_meip(ok);
                    checks++;
                    if (!ok) begin
                        $display("FAIL rand_meip_timeout iter=%0d meip=0 required=1", it);
                        remaining = '0;
                    end else begin
                        passed++;
                        pulse_ack();
                        wb_read(3'd3, q);
                        checks++;
                        if (q !== 32'(exp_id))
                            $display("FAIL rand_claim iter=%0d got=%0d required=%0d", it, q, exp_id);
                        else passed++;
                        wb_write(3'd4, 32'(exp_id), 4'h1);
                        remaining[exp_id - 1] = 1'b0;
                    end
                end
                repeat (MEIP_LAT + 2) @(negedge clk);
                wb_read(3'd0, q);
                checks++;
                if (q !== ((phase == 0) ? {24'd0, mask & ~en} : 32'd0) || meip_o !== 1'b0)
                    $display("FAIL rand_leftover iter=%0d phase=%0d pend=%h meip=%b required %h/0",
                             it, phase, q, meip_o, (phase == 0) ? (mask & ~en) : 8'h00);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        wb.wb_cyc_i = 1'b1; wb.wb_stb_i = 1'b1; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = 32'h4; wb.wb_sel_i = 4'hF;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            checks++;
            if (wb.wb_ack_o !== (k % 2 == 1))
                $display("FAIL b2b_ack cycle=%0d ack=%b required=%b", k, wb.wb_ack_o, k % 2 == 1);
            else passed++;
        end
        @(negedge clk);
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0;
    endtask

    initial begin
        wb.wb_cyc_i = 1'b0; wb.wb_stb_i = 1'b0; wb.wb_we_i = 1'b0;
        wb.wb_adr_i = '0;   wb.wb_dat_i = '0;   wb.wb_sel_i = '0;
        test_reset();
        test_edge_claim();
        test_two_sources();
        test_level();
        test_reset_mid_claim();
        test_fast();
        test_fast_random();
        test_random_claims();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
